pwm_multich: RTL and testbench

- Parametrised successor to the single-channel button-controlled PWM: CHANNELS independent PWM outputs with a shared period counter and a shared debounce tick.
- Each channel has its own debounced inc/dec buttons, saturating duty register and glitch-free shadowed duty update.
- Optional interleaved (multiphase) mode staggers the channels evenly across the period.
- Sits between the pad inputs (buttons, mode pins) and the PWM output pins of the top-level wrapper.

---
 rtl/pwm_debounce.sv | 26 ++
 rtl/pwm_multich.sv | 121 ++++++++++++
 tb/tb_pwm_multich.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_debounce.sv
// Tick-enabled two-stage button sampler.
// Emits a one-cycle event on the tick that first sees the button pressed.
module pwm_debounce (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic evt
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else if (tick) begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    assign evt = tick & s1 & ~s2;

endmodule

// File: rtl/pwm_multich.sv
// Multichannel PWM with shared period counter and debounce tick.
// Per-channel saturating duty, shadowed at period wrap, optional phase stagger.
module pwm_multich #(
    parameter  int CHANNELS  = 2,
    parameter  int PERIOD    = 10,
    parameter  int DEB_DIV   = 25000000,
    parameter  int DUTY_INIT = 5,
    parameter  int STEP      = 1,
    localparam int CNT_W     = $clog2(PERIOD + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      phase_en,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*CNT_W-1:0] duty_o,
    output logic                      tick_o
);

    localparam int DEB_W = $clog2(DEB_DIV);
    localparam int PH    = PERIOD / CHANNELS;

    logic [DEB_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    pwm_cnt;
    logic                wrap;
    logic [CHANNELS-1:0] inc_evt;
    logic [CHANNELS-1:0] dec_evt;

    assign tick_o = (div_cnt == DEB_W'(DEB_DIV - 1));
    assign wrap   = (pwm_cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick_o) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (!en || wrap) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [CNT_W:0] OFS = (CNT_W + 1)'(i * PH);

        logic [CNT_W-1:0] duty_q;
        logic [CNT_W-1:0] duty_act;
        logic [CNT_W-1:0] ph;
        logic [CNT_W:0]   up;
        logic [CNT_W:0]   sum;
        logic             out_q;

        pwm_debounce u_inc (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick_o),
            .btn   (inc[i]),
            .evt   (inc_evt[i])
        );

        pwm_debounce u_dec (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick_o),
            .btn   (dec[i]),
            .evt   (dec_evt[i])
        );

        // Offsets stay below PERIOD, so one subtract completes the modulo
        always_comb begin
            up  = {1'b0, duty_q} + (CNT_W + 1)'(STEP);
            sum = {1'b0, pwm_cnt};
            if (phase_en) begin
                sum = sum + OFS;
            end
            if (sum >= (CNT_W + 1)'(PERIOD)) begin
                sum = sum - (CNT_W + 1)'(PERIOD);
            end
            ph = sum[CNT_W-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty_q <= CNT_W'(DUTY_INIT);
            end else if (inc_evt[i] && !dec_evt[i]) begin
                duty_q <= (up > (CNT_W + 1)'(PERIOD)) ?
                          CNT_W'(PERIOD) : up[CNT_W-1:0];
            end else if (dec_evt[i] && !inc_evt[i]) begin
                duty_q <= (duty_q < CNT_W'(STEP)) ?
                          '0 : duty_q - CNT_W'(STEP);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty_act <= CNT_W'(DUTY_INIT);
                out_q    <= 1'b0;
            end else begin
                if (!en || wrap) begin
                    duty_act <= duty_q;
                end
                out_q <= en & (ph < duty_act);
            end
        end

        assign pwm_out[i]                 = out_q;
        assign duty_o[i*CNT_W +: CNT_W]   = duty_q;
    end

endmodule

// File: tb/tb_pwm_multich.sv
// Self-checking bench for pwm_multich.
// Cycle model in plain arithmetic plus literal waveform/duty checks.
module tb_pwm_multich;

    localparam int CH = 2;
    localparam int P  = 10;
    localparam int DD = 4;
    localparam int DI = 5;
    localparam int ST = 1;
    localparam int W  = 4;
    localparam int PH = P / CH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            phase_en = 1'b0;
    logic [CH-1:0]   inc = '0;
    logic [CH-1:0]   dec = '0;
    logic [CH-1:0]   pwm_out;
    logic [CH*W-1:0] duty_o;
    logic            tick_o;

    pwm_multich #(
        .CHANNELS  (CH),
        .PERIOD    (P),
        .DEB_DIV   (DD),
        .DUTY_INIT (DI),
        .STEP      (ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .phase_en (phase_en),
        .inc      (inc),
        .dec      (dec),
        .pwm_out  (pwm_out),
        .duty_o   (duty_o),
        .tick_o   (tick_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: positions as integers, wrap via %
    int m_div;
    int m_cnt;
    int m_q   [CH];
    int m_act [CH];
    bit m_out [CH];
    bit hi1 [CH], hi2 [CH], hd1 [CH], hd2 [CH];

    task automatic m_reset();
        m_div = 0;
        m_cnt = 0;
        for (int c = 0; c < CH; c++) begin
            m_q[c]   = DI;
            m_act[c] = DI;
            m_out[c] = 1'b0;
            hi1[c] = 0; hi2[c] = 0; hd1[c] = 0; hd2[c] = 0;
        end
    endtask

    task automatic m_step();
        bit tick;
        bit ie, de;
        int nq, ph;
        tick = (m_div == DD - 1);
        for (int c = 0; c < CH; c++) begin
            ie = tick && hi1[c] && !hi2[c];
            de = tick && hd1[c] && !hd2[c];
            nq = m_q[c];
            if (ie && !de)
                nq = (m_q[c] + ST > P) ? P : m_q[c] + ST;
            else if (de && !ie)
                nq = (m_q[c] - ST < 0) ? 0 : m_q[c] - ST;
            if (tick) begin
                hi2[c] = hi1[c]; hi1[c] = inc[c];
                hd2[c] = hd1[c]; hd1[c] = dec[c];
            end
            ph = phase_en ? (m_cnt + c * PH) % P : m_cnt;
            m_out[c] = en && (ph < m_act[c]);
            if (!en || m_cnt == P - 1)
                m_act[c] = m_q[c];
            m_q[c] = nq;
        end
        m_cnt = en ? (m_cnt + 1) % P : 0;
        m_div = (m_div + 1) % DD;
    endtask

    initial m_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("tick_o", 32'(tick_o), 32'(m_div == DD - 1));
            for (int c = 0; c < CH; c++) begin
                check($sformatf("duty_o[%0d]", c),
                      32'(duty_o[c*W +: W]), 32'(m_q[c]));
                check($sformatf("pwm_out[%0d]", c),
                      32'(pwm_out[c]), 32'(m_out[c]));
            end
        end
    end

    task automatic window(output int n0, output int n1, output int nd);
        n0 = 0; n1 = 0; nd = 0;
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            n0 += int'(pwm_out[0]);
            n1 += int'(pwm_out[1]);
            nd += int'(pwm_out[0] != pwm_out[1]);
        end
    endtask

    task automatic press(input int c, input bit up, input bit dn);
        @(negedge clk);
        inc[c] = up;
        dec[c] = dn;
        repeat (8) @(negedge clk);
        inc[c] = 1'b0;
        dec[c] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    int n0, n1, nd;
    bit s0 [2*P];
    bit s1 [2*P];

    initial begin
        en = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (23) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst pwm_out", 32'(pwm_out), 32'd0);
        check("rst duty0", 32'(duty_o[0 +: W]), 32'd5);
        check("rst duty1", 32'(duty_o[W +: W]), 32'd5);
        check("rst tick_o", 32'(tick_o), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        window(n0, n1, nd);
        check("aligned ch0 highs", 32'(n0), 32'd5);
        check("aligned ch1 highs", 32'(n1), 32'd5);
        check("aligned skew", 32'(nd), 32'd0);

        @(negedge clk);
        phase_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2 * P; k++) begin
            @(negedge clk);
            s0[k] = pwm_out[0];
            s1[k] = pwm_out[1];
        end
        n0 = 0; n1 = 0; nd = 0;
        for (int k = 0; k < P; k++) begin
            n0 += int'(s0[k]);
            n1 += int'(s1[k]);
            nd += int'(s1[k + PH] != s0[k]);
        end
        check("phase ch0 highs", 32'(n0), 32'd5);
        check("phase ch1 highs", 32'(n1), 32'd5);
        check("phase shift", 32'(nd), 32'd0);
        @(negedge clk);
        phase_en = 1'b0;

        @(negedge clk);
        inc[0] = 1'b1;
        repeat (12) @(negedge clk);
        inc[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("hold duty0", 32'(duty_o[0 +: W]), 32'd6);
        repeat (P) @(negedge clk);
        window(n0, n1, nd);
        check("hold ch0 highs", 32'(n0), 32'd6);

        for (int k = 0; k < 7; k++) press(0, 1'b1, 1'b0);
        check("sat duty0", 32'(duty_o[0 +: W]), 32'd10);
        repeat (P) @(negedge clk);
        window(n0, n1, nd);
        check("sat ch0 highs", 32'(n0), 32'd10);
        for (int k = 0; k < 12; k++) press(0, 1'b0, 1'b1);
        check("floor duty0", 32'(duty_o[0 +: W]), 32'd0);
        repeat (P) @(negedge clk);
        window(n0, n1, nd);
        check("floor ch0 highs", 32'(n0), 32'd0);
        check("floor ch1 highs", 32'(n1), 32'd5);

        press(1, 1'b1, 1'b1);
        check("both duty1", 32'(duty_o[W +: W]), 32'd5);
        check("both duty0", 32'(duty_o[0 +: W]), 32'd0);

        press(0, 1'b1, 1'b0);
        press(0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en off pwm_out", 32'(pwm_out), 32'd0);
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        window(n0, n1, nd);
        check("re-en ch0 highs", 32'(n0), 32'd2);
        check("re-en ch1 highs", 32'(n1), 32'd5);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
